// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: fetches an 8-word line over req/ack, writes it to the cache arrays in one cycle, aborts on memory timeout
module icache_refill_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         miss_req,
  input  logic [31:0]  miss_addr,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         fill_we,
  output logic [4:0]   fill_index,
  output logic [23:0]  fill_tag,
  output logic [255:0] fill_data,
  output logic         fill_valid,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE, S_ABORT} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t r_state;
  logic [28:0] r_base;
  logic [2:0] r_wcnt;
  logic [7:0] r_to;
  logic [255:0] r_data;
  logic r_req, r_we, r_busy, r_done, r_err;
  logic w_unused;
  assign w_unused = &{1'b0, miss_addr[2:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base <= '0;
      r_wcnt <= '0;
      r_to <= '0;
      r_data <= '0;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_we <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (miss_req) begin
          r_state <= S_FETCH;
          r_base <= miss_addr[31:3];
          r_wcnt <= '0;
          r_to <= '0;
          r_req <= 1'b1;
          r_busy <= 1'b1;
        end
        S_FETCH: if (mem_ack) begin
          r_data[{~r_wcnt, 5'd0} +: 32] <= mem_rdata;
          r_wcnt <= r_wcnt + 3'd1;
          r_to <= '0;
          if (r_wcnt == 3'd7) begin
            r_state <= S_WRITE;
            r_req <= 1'b0;
            r_we <= 1'b1;
          end
        end else if (r_to == TO_LAST) begin
          r_state <= S_ABORT;
          r_req <= 1'b0;
          r_err <= 1'b1;
        end else begin
          r_to <= r_to + 8'd1;
        end
        S_WRITE: begin
          r_state <= S_DONE;
          r_done <= 1'b1;
        end
        S_DONE, S_ABORT: begin
          r_state <= S_IDLE;
          r_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign mem_req = r_req;
  assign mem_addr = {r_base, r_wcnt};
  assign fill_we = r_we;
  assign fill_valid = r_we;
  assign fill_index = r_base[4:0];
  assign fill_tag = r_base[28:5];
  assign fill_data = r_data;
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed timeline on two instances (TIMEOUT 255 and 4) checked every cycle against an event-level model
module tb_icache_refill_ctrl;
  localparam int N = 150;
  logic clk = 1'b0;
  logic reset, miss_req, mem_ack;
  logic [31:0] miss_addr, mem_rdata;
  logic [1:0] mreq, fwe, fvalid, busy, done, err;
  logic [1:0][31:0] maddr;
  logic [1:0][4:0] fidx;
  logic [1:0][23:0] ftag;
  logic [1:0][255:0] fdata;
  logic rst_v [N];
  logic miss_v [N];
  logic ack_v [N];
  logic [31:0] addr_v [N];
  logic [31:0] rdata_v [N];
  logic [5:0] e_ctl [2][N];
  logic [31:0] e_addr [2][N];
  logic [28:0] e_meta [2][N];
  logic [255:0] e_data [2][N];
  bit c_addr [2][N];
  bit c_meta [2][N];
  bit c_data [2][N];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  icache_refill_ctrl #(.TIMEOUT(255)) u_dut0 (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
    .mem_req(mreq[0]), .mem_addr(maddr[0]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_we(fwe[0]), .fill_index(fidx[0]), .fill_tag(ftag[0]), .fill_data(fdata[0]),
    .fill_valid(fvalid[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );
  icache_refill_ctrl #(.TIMEOUT(4)) u_dut1 (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
    .mem_req(mreq[1]), .mem_addr(maddr[1]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_we(fwe[1]), .fill_index(fidx[1]), .fill_tag(ftag[1]), .fill_data(fdata[1]),
    .fill_valid(fvalid[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );
  task automatic miss(input int e, input logic [31:0] a);
    miss_v[e] = 1'b1;
    addr_v[e] = a;
  endtask
  task automatic acks(input int first, input int step, input int cnt, input logic [31:0] d0);
    for (int i = 0; i < cnt; i++) begin
      ack_v[first + i * step] = 1'b1;
      rdata_v[first + i * step] = d0 + 32'(i);
    end
  endtask
  task automatic zero(input int d, input int n);
    e_ctl[d][n] = '0;
    e_addr[d][n] = '0;
    e_meta[d][n] = '0;
    e_data[d][n] = '0;
    c_addr[d][n] = 1'b1;
    c_meta[d][n] = 1'b1;
    c_data[d][n] = 1'b1;
  endtask
  task automatic put_fetch(input int d, input int n, input logic [28:0] base, input int k);
    e_ctl[d][n] = 6'b110000;
    e_addr[d][n] = {base, 3'(k)};
    e_meta[d][n] = base;
    c_addr[d][n] = 1'b1;
    c_meta[d][n] = 1'b1;
  endtask
  // Outputs indexed by edge: value seen just after that rising edge; ctl = {req,busy,we,valid,done,err}
  task automatic model(input int d, input int to);
    int n, c, s, k, f, outc;
    logic [28:0] base;
    logic [31:0] w [8];
    n = 0;
    while (n < N) begin
      if (rst_v[n]) begin
        zero(d, n);
        n++;
      end else if (!miss_v[n]) begin
        n++;
      end else begin
        c = n; base = addr_v[n][31:3]; s = c; k = 0; outc = 0; f = N;
        put_fetch(d, c, base, 0);
        for (int m = c + 1; m < N && outc == 0; m++) begin
          if (rst_v[m]) begin
            outc = 3; f = m; zero(d, m);
          end else begin
            if (ack_v[m]) begin w[k] = rdata_v[m]; k++; s = m; end
            if (k == 8) begin outc = 1; f = m; end
            else if (!ack_v[m] && m - s == to) begin outc = 2; f = m; end
            else put_fetch(d, m, base, k);
          end
        end
        if (outc == 1) begin
          e_ctl[d][f] = 6'b011100;
          e_meta[d][f] = base;
          c_meta[d][f] = 1'b1;
          e_data[d][f] = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
          c_data[d][f] = 1'b1;
          if (f + 1 >= N) n = N;
          else if (rst_v[f + 1]) begin zero(d, f + 1); n = f + 2; end
          else begin
            e_ctl[d][f + 1] = 6'b010010;
            if (f + 2 < N && rst_v[f + 2]) zero(d, f + 2);
            n = f + 3;
          end
        end else if (outc == 2) begin
          e_ctl[d][f] = 6'b010001;
          if (f + 1 < N && rst_v[f + 1]) zero(d, f + 1);
          n = f + 2;
        end else if (outc == 3) n = f + 1;
        else n = N;
      end
    end
  endtask
  task automatic cmp(input string nm, input int d, input int n, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d edge %0d: got %h want %h", nm, d, n, got, want);
    end
  endtask
  task automatic check(input int n);
    for (int d = 0; d < 2; d++) begin
      cmp("ctl", d, n, 256'({mreq[d], busy[d], fwe[d], fvalid[d], done[d], err[d]}), 256'(e_ctl[d][n]));
      if (c_addr[d][n]) cmp("mem_addr", d, n, 256'(maddr[d]), 256'(e_addr[d][n]));
      if (c_meta[d][n]) cmp("tag_index", d, n, 256'({ftag[d], fidx[d]}), 256'(e_meta[d][n]));
      if (c_data[d][n]) cmp("fill_data", d, n, fdata[d], e_data[d][n]);
    end
    if (n == 2) cmp("pin_addr_first", 0, n, 256'(maddr[0]), 256'(32'h00001230));
    if (n == 10) cmp("pin_addr_last", 0, n, 256'(maddr[0]), 256'(32'h00001237));
    if (n == 11) begin
      cmp("pin_we_plus10", 0, n, 256'(fwe[0]), 256'(1'b1));
      cmp("pin_index", 0, n, 256'(fidx[0]), 256'(5'd6));
      cmp("pin_tag", 0, n, 256'(ftag[0]), 256'(24'h000012));
      cmp("pin_data", 0, n, fdata[0], {32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7});
    end
    if (n == 12) cmp("pin_done_plus11", 0, n, 256'(done[0]), 256'(1'b1));
    if (n == 49) cmp("pin_we_plus34", 0, n, 256'(fwe[0]), 256'(1'b1));
    if (n == 20) cmp("pin_err_wait", 1, n, 256'(err[1]), 256'(1'b1));
    if (n == 70) cmp("pin_err_timeout", 1, n, 256'(err[1]), 256'(1'b1));
    if (n == 71) cmp("pin_busy_after_err", 1, n, 256'(busy[1]), 256'(1'b0));
    if (n == 112) cmp("pin_reset_mid", 0, n, 256'({mreq[0], busy[0], fwe[0], done[0], maddr[0]}), 256'(0));
    if (n == 130) cmp("pin_wrap_first", 0, n, 256'(maddr[0]), 256'(32'hFFFFFFF8));
    if (n == 138) cmp("pin_wrap_last", 0, n, 256'(maddr[0]), 256'(32'hFFFFFFFF));
    if (n == 139) cmp("pin_wrap_meta", 0, n, 256'({ftag[0], fidx[0]}), 256'({24'hFFFFFF, 5'd31}));
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      rst_v[i] = 1'b0; miss_v[i] = 1'b0; ack_v[i] = 1'b0; addr_v[i] = '0; rdata_v[i] = '0;
      for (int d = 0; d < 2; d++) begin
        e_ctl[d][i] = '0; e_addr[d][i] = '0; e_meta[d][i] = '0; e_data[d][i] = '0;
        c_addr[d][i] = 1'b0; c_meta[d][i] = 1'b0; c_data[d][i] = 1'b0;
      end
    end
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    miss(2, 32'h00001234);   acks(4, 1, 8, 32'hA0);
    miss(16, 32'h00001234);  acks(21, 4, 8, 32'hA0);
    miss(26, 32'hDEADBEEF);  miss(36, 32'hDEADBEEF);
    acks(50, 1, 1, 32'h0BADF00D); acks(60, 1, 1, 32'h0BADF00D);
    miss(62, 32'h00000040);  acks(64, 1, 3, 32'hC0); acks(80, 1, 5, 32'hC3);
    miss(90, 32'h00000088);  acks(92, 1, 8, 32'hB0);
    miss(104, 32'h00ABCDEF); acks(106, 1, 6, 32'hD0);
    rst_v[112] = 1'b1;
    miss(115, 32'h00ABCDEF); acks(117, 1, 8, 32'hD0);
    miss(130, 32'hFFFFFFFF); acks(132, 1, 8, 32'hE0);
    model(0, 255);
    model(1, 4);
    for (int n = 0; n < N; n++) begin
      reset = rst_v[n];
      miss_req = miss_v[n];
      miss_addr = addr_v[n];
      mem_ack = ack_v[n];
      mem_rdata = rdata_v[n];
      @(posedge clk);
      #1;
      check(n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
